// File: rtl/imem_fetch_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : imem_fetch_ctrl_pkg
// Brief    : Shared state encoding, constants and fetch-buffer entry type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] c_nop_inst = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam int c_entry_w = $bits(fetch_entry_t);

endpackage : imem_fetch_ctrl_pkg

`default_nettype wire

// File: rtl/ifetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : ifetch_fifo
// Brief    : Synchronous FIFO with flush; exposes full/empty/count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_cnt_max);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule : ifetch_fifo

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : imem_fetch_ctrl
// Brief    : Instruction-fetch sequencer: PC, memory drive, fetch buffer,
//            redirect/halt/fault handling. IFETCH_PERF_EN adds perf counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_DEPTH  = 1001,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = c_nop_inst
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
`ifdef IFETCH_PERF_EN
  output logic        halted,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`else
  output logic        halted
`endif
);

  localparam int          c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0] c_mem_depth = 30'(MEM_DEPTH);
  localparam logic [31:0] c_pc_step   = 32'd4;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic               r_imem_en;

  logic               w_push;
  logic               w_pop;
  logic               w_flush;
  logic               w_oor;
  fetch_entry_t       w_entry;
  fetch_entry_t       w_head;
  logic [c_entry_w-1:0] w_rd_data;
  logic               w_full;
  logic               w_empty;
  logic [c_cnt_w-1:0] w_count;
  logic               w_unused;

  assign w_unused = &{1'b0, redir_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_imem_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_imem_en <= (w_state_nxt == ST_FETCH);
    end
  end

  // Priority: redirect, halt_req, out-of-range detection, normal push.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_entry     = '0;
    w_pop       = out_valid && out_ready;
    w_oor       = (r_pc[31:2] >= c_mem_depth);

    if (r_state == ST_IDLE) begin
      w_state_nxt = ST_FETCH;
    end else if (redir_valid) begin
      w_flush     = 1'b1;
      w_pop       = 1'b0;
      w_pc_nxt    = {redir_pc[31:2], 2'b00};
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (halt_req) begin
            w_state_nxt = ST_HALT;
          end else if (!w_full || w_pop) begin
            w_push = 1'b1;
            if (w_oor) begin
              w_entry     = '{inst: NOP_INST, pc: r_pc, fault: 1'b1};
              w_state_nxt = ST_FAULT;
            end else begin
              w_entry  = '{inst: imem_inst, pc: r_pc, fault: 1'b0};
              w_pc_nxt = r_pc + c_pc_step;
            end
          end
        end
        ST_HALT: begin
          if (resume && !halt_req) w_state_nxt = ST_FETCH;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_flush),
    .wr_data (w_entry),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign w_head    = w_rd_data;
  assign imem_en   = r_imem_en;
  assign imem_addr = {2'b00, r_pc[31:2]};
  assign out_valid = !w_empty;
  // Stale storage is masked so the outputs read zero whenever nothing is valid.
  assign out_inst  = out_valid ? w_head.inst : '0;
  assign out_pc    = out_valid ? w_head.pc   : '0;
  assign out_fault = out_valid && w_head.fault;
  assign halted    = (r_state == ST_HALT) && (w_count == '0);

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push && (r_perf_fetch != '1))
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if ((r_state == ST_FETCH) && w_full && !w_pop && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_flush && !w_empty && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule : imem_fetch_ctrl

`default_nettype wire
